// File: rtl/exec_stage_unit_if.sv
// E-stage operand/result bundle between the forwarding muxes, the execute slice
// and the memory stage.
interface exec_stage_unit_if #(
    parameter int N = 64,
    parameter int W = 32,
    parameter int R = 5
);
    logic [N-1:0] srca;
    logic [N-1:0] srcb;
    logic [3:0]   alucontrol;
    logic [N-1:0] writedata_e;
    logic [R-1:0] writereg_e;
    logic [W-1:0] adda;
    logic [W-1:0] addb;
    logic [W-1:0] sum;
    logic [N-1:0] aluout_e;
    logic         zero;
    logic [N-1:0] aluout_m;
    logic [N-1:0] writedata_m;
    logic [R-1:0] writereg_m;

    modport master (
        output srca, srcb, alucontrol, writedata_e, writereg_e, adda, addb,
        input  sum, aluout_e, zero, aluout_m, writedata_m, writereg_m
    );

    modport slave (
        input  srca, srcb, alucontrol, writedata_e, writereg_e, adda, addb,
        output sum, aluout_e, zero, aluout_m, writedata_m, writereg_m
    );
endinterface

// File: rtl/exec_stage_unit.sv
// Execute-stage slice: combinational ALU + address adder feeding the E-to-M
// pipeline register (async active-low clear).
module exec_stage_unit #(
    parameter int N = 64,
    parameter int W = 32,
    parameter int R = 5
) (
    input  logic               clk,
    input  logic               reset,
    exec_stage_unit_if.slave   bus
);
    typedef struct packed {
        logic [N-1:0] aluout;
        logic [N-1:0] writedata;
        logic [R-1:0] writereg;
    } em_t;

    logic [5:0]   shamt;
    logic [N-1:0] add_n;
    logic [N-1:0] sub_n;
    logic         lt_u;
    logic         lt_s;
    logic [N-1:0] alu;
    em_t          em_d;
    em_t          em_q;

    assign shamt = bus.srcb[5:0];
    assign add_n = bus.srca + bus.srcb;
    assign sub_n = bus.srca - bus.srcb;
    assign lt_u  = bus.srca < bus.srcb;
    assign lt_s  = $signed(bus.srca) < $signed(bus.srcb);

    always_comb begin
        alu = '0;
        case (bus.alucontrol)
            4'h0: alu = bus.srca & bus.srcb;
            4'h1: alu = bus.srca | bus.srcb;
            4'h2: alu = add_n;
            4'h3: alu = bus.srca ^ bus.srcb;
            4'h4: alu = ~(bus.srca | bus.srcb);
            4'h5: alu = {{(N-1){1'b0}}, lt_u};
            4'h6: alu = sub_n;
            4'h7: alu = {{(N-1){1'b0}}, lt_s};
            4'h8: alu = bus.srca << shamt;
            4'h9: alu = bus.srca >> shamt;
            4'hA: alu = $signed(bus.srca) >>> shamt;
            4'hB: alu = bus.srcb << 16;
            // word ops keep the low 32 bits and sign-extend to full width
            4'hC: alu = {{(N-32){add_n[31]}}, add_n[31:0]};
            4'hD: alu = {{(N-32){sub_n[31]}}, sub_n[31:0]};
            default: alu = '0;
        endcase
    end

    assign bus.aluout_e = alu;
    assign bus.zero     = (alu == '0);
    assign bus.sum      = bus.adda + bus.addb;

    assign em_d = '{aluout: alu, writedata: bus.writedata_e, writereg: bus.writereg_e};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) em_q <= '0;
        else        em_q <= em_d;
    end

    assign bus.aluout_m    = em_q.aluout;
    assign bus.writedata_m = em_q.writedata;
    assign bus.writereg_m  = em_q.writereg;
endmodule

// File: tb/tb_exec_stage_unit.sv
// Directed + randomized bench for exec_stage_unit against an arithmetic reference model.
module tb_exec_stage_unit;
    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    exec_stage_unit_if #(.N(64), .W(32), .R(5)) bus();
    exec_stage_unit #(.N(64), .W(32), .R(5)) dut (.clk(clk), .reset(reset), .bus(bus));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_alu(input logic [63:0] a, input logic [63:0] b,
                                            input logic [3:0] op);
        logic [63:0] p2;
        int          w;
        p2 = 64'd1 << b[5:0];
        case (op)
            4'd0:  return a & b;
            4'd1:  return a | b;
            4'd2:  return a + b;
            4'd3:  return a ^ b;
            4'd4:  return ~(a | b);
            4'd5:  return (a < b) ? 64'd1 : 64'd0;
            4'd6:  return a - b;
            4'd7:  return (longint'(a) < longint'(b)) ? 64'd1 : 64'd0;
            4'd8:  return a * p2;
            4'd9:  return a / p2;
            4'd10: return (a / p2) | (a[63] ? ~(64'hFFFF_FFFF_FFFF_FFFF / p2) : 64'd0);
            4'd11: return b * 64'd65536;
            4'd12: begin w = int'(a[31:0] + b[31:0]); return 64'(longint'(w)); end
            4'd13: begin w = int'(a[31:0] - b[31:0]); return 64'(longint'(w)); end
            default: return 64'd0;
        endcase
    endfunction

    task automatic drive(input logic [63:0] a, input logic [63:0] b, input logic [3:0] op,
                         input logic [63:0] wd, input logic [4:0] wr,
                         input logic [31:0] aa, input logic [31:0] ab);
        bus.srca = a; bus.srcb = b; bus.alucontrol = op;
        bus.writedata_e = wd; bus.writereg_e = wr;
        bus.adda = aa; bus.addb = ab;
        #1;
    endtask

    task automatic edge_settle();
        @(posedge clk);
        #1;
    endtask

    logic [63:0] exp_alu, exp_wd;
    logic [4:0]  exp_wr;

    initial begin
        reset = 1'b0;
        drive(64'd0, 64'd0, 4'd0, 64'd0, 5'd0, 32'd0, 32'd0);
        #2;
        chk("reset_aluout_m", bus.aluout_m, 64'd0);
        chk("reset_writedata_m", bus.writedata_m, 64'd0);
        chk("reset_writereg_m", 64'(bus.writereg_m), 64'd0);
        drive(64'h55, 64'h0F, 4'd1, 64'h77, 5'd9, 32'd0, 32'd0);
        edge_settle();
        chk("reset_hold_over_edge", bus.aluout_m, 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // 1. ADD wrap
        drive(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'b0010, 64'd0, 5'd0, 32'd0, 32'd0);
        chk("add_wrap_aluout_e", bus.aluout_e, 64'd0);
        chk("add_wrap_zero", 64'(bus.zero), 64'd1);
        edge_settle();
        chk("add_wrap_aluout_m", bus.aluout_m, 64'd0);

        // 2. SUB and compares
        drive(64'd5, 64'd7, 4'b0110, 64'd0, 5'd0, 32'd0, 32'd0);
        chk("sub_aluout_e", bus.aluout_e, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("sub_zero", 64'(bus.zero), 64'd0);
        drive(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'b0111, 64'd0, 5'd0, 32'd0, 32'd0);
        chk("slt", bus.aluout_e, 64'd1);
        drive(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'b0101, 64'd0, 5'd0, 32'd0, 32'd0);
        chk("sltu", bus.aluout_e, 64'd0);
        chk("sltu_zero", 64'(bus.zero), 64'd1);

        // 3. word ops, shifts, LUI
        drive(64'h7FFF_FFFF, 64'd1, 4'b1100, 64'd0, 5'd0, 32'd0, 32'd0);
        chk("addw", bus.aluout_e, 64'hFFFF_FFFF_8000_0000);
        drive(64'h8000_0000_0000_0000, 64'h43, 4'b1010, 64'd0, 5'd0, 32'd0, 32'd0);
        chk("sra", bus.aluout_e, 64'hF000_0000_0000_0000);
        drive(64'd0, 64'h1234, 4'b1011, 64'd0, 5'd0, 32'd0, 32'd0);
        chk("lui", bus.aluout_e, 64'h1234_0000);
        drive(64'h1234, 64'h5678, 4'b1110, 64'd0, 5'd0, 32'd0, 32'd0);
        chk("reserved_zero", 64'(bus.zero), 64'd1);

        // 4. address adder
        drive(64'd0, 64'd0, 4'd0, 64'd0, 5'd0, 32'h0000_0FFC, 32'd4);
        chk("sum_carry", 64'(bus.sum), 64'h1000);
        drive(64'd0, 64'd0, 4'd0, 64'd0, 5'd0, 32'hFFFF_FFFC, 32'd8);
        chk("sum_wrap", 64'(bus.sum), 64'h4);

        // 5. pipeline register
        drive(64'hF0F0, 64'hFF00, 4'b0000, 64'hDEAD_BEEF, 5'd31, 32'd0, 32'd0);
        edge_settle();
        chk("pipe_aluout_m", bus.aluout_m, 64'hF000);
        chk("pipe_writedata_m", bus.writedata_m, 64'hDEAD_BEEF);
        chk("pipe_writereg_m", 64'(bus.writereg_m), 64'd31);
        drive(64'h1, 64'h2, 4'b0010, 64'h99, 5'd3, 32'd0, 32'd0);
        #2;
        chk("pipe_stable_aluout_m", bus.aluout_m, 64'hF000);
        chk("pipe_stable_writereg_m", 64'(bus.writereg_m), 64'd31);

        // 6. asynchronous reset mid-cycle
        edge_settle();
        chk("preload_aluout_m", bus.aluout_m, 64'h3);
        #2;
        reset = 1'b0;
        #1;
        chk("async_aluout_m", bus.aluout_m, 64'd0);
        chk("async_writedata_m", bus.writedata_m, 64'd0);
        chk("async_writereg_m", 64'(bus.writereg_m), 64'd0);
        edge_settle();
        chk("async_hold_aluout_m", bus.aluout_m, 64'd0);
        chk("async_hold_writedata_m", bus.writedata_m, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        drive(64'h10, 64'h20, 4'b0011, 64'hCAFE, 5'd17, 32'd0, 32'd0);
        chk("release_no_capture", bus.aluout_m, 64'd0);
        edge_settle();
        chk("release_aluout_m", bus.aluout_m, 64'h30);
        chk("release_writedata_m", bus.writedata_m, 64'hCAFE);
        chk("release_writereg_m", 64'(bus.writereg_m), 64'd17);

        // randomized sweep against the reference model
        for (int i = 0; i < 300; i++) begin
            logic [63:0] a, b, wd;
            logic [3:0]  op;
            logic [4:0]  wr;
            logic [31:0] aa, ab;
            a  = {$urandom, $urandom};
            b  = {$urandom, $urandom};
            if (i % 4 == 0) b = 64'(a);
            if (i % 5 == 0) a = {32'h0, $urandom};
            op = 4'($urandom_range(15, 0));
            wd = {$urandom, $urandom};
            wr = 5'($urandom);
            aa = $urandom;
            ab = $urandom;
            drive(a, b, op, wd, wr, aa, ab);
            exp_alu = ref_alu(a, b, op);
            exp_wd  = wd;
            exp_wr  = wr;
            chk("rnd_aluout_e", bus.aluout_e, exp_alu);
            chk("rnd_zero", 64'(bus.zero), (exp_alu == 64'd0) ? 64'd1 : 64'd0);
            chk("rnd_sum", 64'(bus.sum), 64'(32'(aa + ab)));
            edge_settle();
            chk("rnd_aluout_m", bus.aluout_m, exp_alu);
            chk("rnd_writedata_m", bus.writedata_m, exp_wd);
            chk("rnd_writereg_m", 64'(bus.writereg_m), 64'(exp_wr));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/exec_stage_unit.md
Name: exec_stage_unit

Overview:
- Execute-stage datapath slice of the 64-bit pipelined MIPS core.
- Contains three parts:
  - a combinational N-bit ALU with a zero flag;
  - a combinational W-bit address adder for PC+4 and branch targets;
  - the E-to-M pipeline register, which has asynchronous reset.
- Sits between the operand-forwarding muxes (E stage) and the memory stage.

Parameters:
- N, 64, datapath/ALU operand width.
- W, 32, address adder width.
- R, 5, register-specifier width.

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- reset, input, 1, asynchronous, active-low. reset=0 clears the pipeline register immediately.
- srca, input, N, ALU operand A.
- srcb, input, N, ALU operand B.
- alucontrol, input, 4, ALU operation select.
- writedata_e, input, N, store data to pipe to M stage.
- writereg_e, input, R, destination register to pipe to M stage.
- adda, input, W, address adder operand A (e.g. PC).
- addb, input, W, address adder operand B (e.g. 4 or immediate<<2).
- sum, output, W, adda+addb (combinational).
- aluout_e, output, N, ALU result (combinational).
- zero, output, 1, 1 when aluout_e == 0 (combinational).
- aluout_m, output, N, registered ALU result.
- writedata_m, output, N, registered store data.
- writereg_m, output, R, registered destination register.

Behaviour:
- Address adder:
  - sum = (adda + addb) mod 2^W.
  - No carry-out; wraps silently.
- ALU encoding (alucontrol):
  - 0000 AND; 0001 OR; 0010 ADD; 0011 XOR; 0100 NOR.
  - 0101 SLTU: 1 if srca < srcb unsigned, else 0.
  - 0110 SUB: srca − srcb.
  - 0111 SLT: signed compare, result 1 or 0.
  - 1000 SLL: srca << srcb[5:0].
  - 1001 SRL: srca >> srcb[5:0], logical.
  - 1010 SRA: srca >> srcb[5:0], arithmetic.
  - 1011 LUI: srcb << 16.
  - 1100 ADDW: sign-extend bits [31:0] of (srca + srcb).
  - 1101 SUBW: sign-extend bits [31:0] of (srca − srcb).
  - 1110, 1111: result 0.
- ALU arithmetic rules:
  - All add/sub wrap mod 2^N.
  - No overflow trap or flag.
  - Shift amounts use only srcb[5:0].
- zero:
  - Reflects the current aluout_e in the same cycle.
  - Is 1 for reserved codes.
- Pipeline register, at rising clk while reset=1:
  - {aluout_m, writedata_m, writereg_m} <= {aluout_e, writedata_e, writereg_e}.
  - Latency 1 cycle.
  - No enable or flush; loads every cycle.
- Reset:
  - While reset=0, all three registered outputs are 0, independent of clk. This includes assertion in the middle of a cycle.
  - The first capture happens on the first rising edge after reset returns to 1.
- Combinational outputs (sum, aluout_e, zero) are unaffected by reset.
- X-free requirement: after reset, all outputs are known given known inputs.

Test Plan:
1. ADD wrap:
   - Stimulus: srca=64'hFFFF_FFFF_FFFF_FFFF, srcb=1, alucontrol=0010.
   - Required: aluout_e=0, zero=1.
   - Required: after 1 edge, aluout_m=0.
2. SUB and compares:
   - SUB: srca=5, srcb=7, alucontrol=0110 → aluout_e=64'hFFFF_FFFF_FFFF_FFFE, zero=0.
   - SLT with srca=−1, srcb=1 → 1.
   - SLTU with the same operands → 0.
3. Word ops and shifts:
   - ADDW: srca=32'h7FFF_FFFF, srcb=1 → 64'hFFFF_FFFF_8000_0000.
   - SRA: srca=64'h8000_0000_0000_0000, srcb=64'h43 (shift amount 3) → 64'hF000_0000_0000_0000.
   - LUI: srcb=16'h1234 → 64'h1234_0000.
4. Address adder:
   - adda=32'h0000_0FFC, addb=4 → sum=32'h0000_1000.
   - adda=32'hFFFF_FFFC, addb=8 → sum=32'h0000_0004.
5. Pipeline register:
   - Stimulus: writedata_e=64'hDEAD_BEEF, writereg_e=5'd31, ALU AND of 64'hF0F0 with 64'hFF00.
   - Required: after one edge, aluout_m=64'hF000, writedata_m=64'hDEAD_BEEF, writereg_m=31.
   - Required: outputs stay stable until the next edge.
6. Asynchronous reset:
   - Load nonzero values into the pipeline register.
   - Drive reset=0 between clock edges.
   - Required: all *_m outputs go to 0 before the next edge, and stay 0 while reset=0.
   - Release reset: the next edge captures the current E-stage inputs.
